aux_perf_monitor: RTL and testbench
===================================

AUX_PERF_MONITOR -- requirements
Module: aux_perf_monitor

Interface
REQ-001 SHALL have parameter ChCnt, default 8; number of event counter channels, range 1..16.
REQ-002 SHALL have parameter CntBit, default 32; width of each counter, range 1..32.
REQ-003 SHALL have parameter SelBit, default 4; width of the channel select input, with 2^SelBit >= ChCnt.
REQ-004 SHALL have port clk, input, 1 bit; single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit; core enable that qualifies all event counting.
REQ-007 SHALL have port evt, input, ChCnt bits; per-channel event strobes, sampled each cycle.
REQ-008 SHALL have port clr, input, 1 bit; synchronous clear of all counters, shadows and flags.
REQ-009 SHALL have port freeze, input, 1 bit; level-sensitive snapshot hold request.
REQ-010 SHALL have port sel, input, SelBit bits; selects the channel shown on data.
REQ-011 SHALL have port data, output, 32 bits; registered value of the selected channel, zero-extended.
REQ-012 SHALL have port ovf, output, ChCnt bits; sticky per-channel overflow flags.
REQ-013 SHALL have port frozen, output, 1 bit; high while the snapshot state is FROZEN.

Function
REQ-014 Counter i SHALL increment by 1 on each clk edge where en && evt[i] && !clr.
REQ-015 When clr is high, all counters, shadows and ovf SHALL be 0 after the edge, overriding any increment or capture in the same cycle.
REQ-016 Overflow SHALL occur when counter i is all-ones and increments; ovf[i] SHALL be set on that edge and held until clr or reset.
REQ-017 The snapshot FSM SHALL have two states: LIVE and FROZEN; reset state is LIVE.
REQ-018 LIVE->FROZEN SHALL occur on an edge with freeze=1; on that edge every shadow[i] SHALL capture the counter value before that edge's increment.
REQ-019 FROZEN->LIVE SHALL occur on an edge with freeze=0; shadows are not updated while FROZEN.
REQ-020 Counters SHALL keep counting in both states; freeze affects only the displayed value.
REQ-021 data SHALL equal counter[sel] (LIVE) or shadow[sel] (FROZEN), registered, with 1-cycle latency from sel, state or counter change.
REQ-022 A sel value >= ChCnt SHALL yield data = 32'h0000_0000.
REQ-023 clr while FROZEN SHALL zero the shadows and keep the FROZEN state.
REQ-024 frozen SHALL be 1 exactly while the FSM is in FROZEN.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously force all counters, shadows, ovf, data and frozen to 0 and the FSM to LIVE, including mid-count and while FROZEN.
REQ-026 After rst_n deasserts, counting SHALL resume on the first rising clk edge.

Configuration
REQ-027 Macro PERF_SATURATE_EN defined: on overflow, counter i SHALL hold at all-ones (saturate) and ovf[i] SHALL be set.
REQ-028 Macro PERF_SATURATE_EN undefined: on overflow, counter i SHALL wrap to 0 and ovf[i] SHALL be set.

Verification
REQ-029 Reset, then en=1, evt[2]=1 for 5 cycles, sel=2 -> data=5 one cycle later; all other channels read 0.
REQ-030 en=0, evt=all-ones for 10 cycles -> all counters remain 0.
REQ-031 Count ch0 to 7, assert freeze, count 3 more, sel=0 -> data=7 and frozen=1; drop freeze -> data=10 one cycle after LIVE.
REQ-032 CntBit=4, 17 events on ch1 -> ovf[1]=1; data=15 with PERF_SATURATE_EN, data=1 without.
REQ-033 clr and evt[0] asserted in the same cycle with counter0=9 -> counter0=0 and ovf=0; with sel=ChCnt -> data=0.
REQ-034 Pulse rst_n low asynchronously between clk edges while FROZEN -> data, ovf and frozen are 0 immediately, with no clk edge.

Source files
------------

// File: rtl/aux_perf_monitor.sv
// Multi-channel event counters with a freezable snapshot readout.
// Define PERF_SATURATE_EN to make counters saturate instead of wrap.
module aux_perf_monitor #(
  parameter int ChCnt  = 8,
  parameter int CntBit = 32,
  parameter int SelBit = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ChCnt-1:0]  evt,
  input  logic              clr,
  input  logic              freeze,
  input  logic [SelBit-1:0] sel,
  output logic [31:0]       data,
  output logic [ChCnt-1:0]  ovf,
  output logic              frozen
);

  typedef enum logic {LIVE, FROZEN} state_t;

  state_t            state;
  logic [CntBit-1:0] cnt [ChCnt];
  logic [CntBit-1:0] shd [ChCnt];
  logic [CntBit-1:0] pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LIVE;
    end else begin
      unique case (state)
        LIVE:    if (freeze) state <= FROZEN;
        FROZEN:  if (!freeze) state <= LIVE;
        default: state <= LIVE;
      endcase
    end
  end

  assign frozen = (state == FROZEN);

  // Shadows sample pre-increment counts on the LIVE->FROZEN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ChCnt; i++) begin
        cnt[i] <= '0;
        shd[i] <= '0;
      end
      ovf <= '0;
    end else if (clr) begin
      for (int i = 0; i < ChCnt; i++) begin
        cnt[i] <= '0;
        shd[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < ChCnt; i++) begin
        if (en && evt[i]) begin
          if (&cnt[i]) begin
            ovf[i] <= 1'b1;
`ifdef PERF_SATURATE_EN
            cnt[i] <= cnt[i];
`else
            cnt[i] <= '0;
`endif
          end else begin
            cnt[i] <= cnt[i] + CntBit'(1);
          end
        end
        if (state == LIVE && freeze) shd[i] <= cnt[i];
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    pick = '0;
    for (int i = 0; i < ChCnt; i++) begin
      if (sel == SelBit'(i)) begin
        pick = (state == FROZEN) ? shd[i] : cnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= 32'(pick);
    end
  end

endmodule

// File: tb/tb_aux_perf_monitor.sv
// Directed bench for aux_perf_monitor (ChCnt=8, CntBit=4, SelBit=4).
module tb_aux_perf_monitor;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  evt;
  logic        clr;
  logic        freeze;
  logic [3:0]  sel;
  logic [31:0] data;
  logic [7:0]  ovf;
  logic        frozen;

  int npass;
  int ntot;

  typedef struct {
    logic        en;
    logic [7:0]  evt;
    logic        clr;
    logic        frz;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [7:0]  ovf;
    logic        frozen;
  } vec_t;

  vec_t tbl [14];

`ifdef PERF_SATURATE_EN
  localparam logic [31:0] OvfCh1 = 32'd15;
  localparam logic [31:0] OvfCh3 = 32'd15;
`else
  localparam logic [31:0] OvfCh1 = 32'd1;
  localparam logic [31:0] OvfCh3 = 32'd2;
`endif

  aux_perf_monitor #(
    .ChCnt (8),
    .CntBit(4),
    .SelBit(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .evt   (evt),
    .clr   (clr),
    .freeze(freeze),
    .sel   (sel),
    .data  (data),
    .ovf   (ovf),
    .frozen(frozen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(input logic e, input logic [7:0] ev, input logic c,
                      input logic f, input logic [3:0] s);
    en = e; evt = ev; clr = c; freeze = f; sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n, input logic e, input logic [7:0] ev,
                       input logic f, input logic [3:0] s);
    for (int k = 0; k < n; k++) step(e, ev, 1'b0, f, s);
  endtask

  initial begin
    npass = 0;
    ntot = 0;
    rst_n = 1'b0;
    en = 1'b0; evt = '0; clr = 1'b0; freeze = 1'b0; sel = '0;

    // ch2 counts to 5, then en=0 with every strobe high changes nothing
    tbl[0]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4'd2, 32'd0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4'd2, 32'd1, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4'd2, 32'd2, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4'd2, 32'd3, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4'd2, 32'd4, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 4'd2, 32'd5, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 4'd3, 32'd0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 32'd0, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 8'hff, 1'b0, 1'b0, 4'd2, 32'd5, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 8'hff, 1'b0, 1'b0, 4'd1, 32'd0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'hff, 1'b0, 1'b0, 4'd7, 32'd0, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 8'hff, 1'b0, 1'b0, 4'd0, 32'd0, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 8'hff, 1'b0, 1'b0, 4'd2, 32'd5, 8'h00, 1'b0};
    tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 4'd9, 32'd0, 8'h00, 1'b0};

    #12 rst_n = 1'b1;
    #1;
    check("reset_data", data, 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_frozen", 32'(frozen), 32'd0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].en, tbl[i].evt, tbl[i].clr, tbl[i].frz, tbl[i].sel);
      check($sformatf("vec%0d_data", i), data, tbl[i].data);
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      check($sformatf("vec%0d_frozen", i), 32'(frozen), 32'(tbl[i].frozen));
    end

    // snapshot: ch0 to 7, freeze, 3 more counts, then release
    step(1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    steps(7, 1'b1, 8'h01, 1'b0, 4'd0);
    step(1'b1, 8'h01, 1'b0, 1'b1, 4'd0);
    check("frz_enter", 32'(frozen), 32'd1);
    steps(2, 1'b1, 8'h01, 1'b1, 4'd0);
    check("frz_data", data, 32'd7);
    check("frz_held", 32'(frozen), 32'd1);
    step(1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
    check("frz_exit", 32'(frozen), 32'd0);
    check("frz_exit_lag", data, 32'd7);
    step(1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
    check("live_data", data, 32'd10);

    // overflow on ch1 after 17 events
    step(1'b0, 8'h00, 1'b1, 1'b0, 4'd1);
    steps(17, 1'b1, 8'h02, 1'b0, 4'd1);
    step(1'b1, 8'h00, 1'b0, 1'b0, 4'd1);
    check("ovf_data", data, OvfCh1);
    check("ovf_flag", 32'(ovf), 32'h02);
    steps(2, 1'b1, 8'h00, 1'b0, 4'd1);
    check("ovf_sticky", 32'(ovf), 32'h02);

    // clr beats a same-cycle increment; out-of-range sel reads zero
    steps(9, 1'b1, 8'h01, 1'b0, 4'd0);
    check("pre_clr_cnt", data, 32'd8);
    step(1'b1, 8'h01, 1'b1, 1'b0, 4'd8);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_sel_oob", data, 32'd0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
    check("clr_cnt0", data, 32'd0);

    // clr while frozen zeroes shadows and keeps FROZEN
    steps(3, 1'b1, 8'h01, 1'b0, 4'd0);
    step(1'b1, 8'h00, 1'b0, 1'b1, 4'd0);
    step(1'b1, 8'h00, 1'b0, 1'b1, 4'd0);
    check("frz2_data", data, 32'd3);
    step(1'b1, 8'h00, 1'b1, 1'b1, 4'd0);
    check("clr_frz_state", 32'(frozen), 32'd1);
    step(1'b1, 8'h00, 1'b0, 1'b1, 4'd0);
    check("clr_frz_shadow", data, 32'd0);

    // async reset between edges while frozen
    step(1'b1, 8'h00, 1'b0, 1'b0, 4'd3);
    steps(18, 1'b1, 8'h08, 1'b0, 4'd3);
    step(1'b1, 8'h00, 1'b0, 1'b1, 4'd3);
    step(1'b1, 8'h00, 1'b0, 1'b1, 4'd3);
    check("pre_rst_data", data, OvfCh3);
    check("pre_rst_ovf", 32'(ovf), 32'h08);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", data, 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    check("arst_frozen", 32'(frozen), 32'd0);
    #3 rst_n = 1'b1;
    freeze = 1'b0;
    step(1'b1, 8'h01, 1'b0, 1'b0, 4'd0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
    check("post_rst_count", data, 32'd1);
    step(1'b1, 8'h00, 1'b0, 1'b0, 4'd3);
    check("post_rst_ch3", data, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
